pipe_ctrl: RTL

Parametrised pipeline control unit for the RV32 core. Arbitrates redirect requests from the execute unit and the interrupt input and turns each accepted redirect into a registered jump pulse plus a multi-cycle flush window. It merges N hold requesters into the stall signal for fetch/decode and keeps a saturating stall-cycle counter for debug. It sits between the EXU, the interrupt source and the IFU/IDU pipeline registers.

---
 rtl/pipe_ctrl_if.sv | 30 +++
 rtl/pipe_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline control unit and its EXU / IRQ / IFU-IDU neighbours.
// master = requester/consumer side, slave = pipe_ctrl side.
interface pipe_ctrl_if #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned NUM_HOLD = 3,
   parameter int unsigned CNT_W    = 16
);
   logic                jump_en_i;
   logic [ADDR_W-1:0]   jump_addr_i;
   logic [NUM_HOLD-1:0] hold_req_i;
   logic                irq_req_i;
   logic [ADDR_W-1:0]   irq_vec_i;
   logic                cnt_clr_i;
   logic                jump_en_o;
   logic [ADDR_W-1:0]   jump_addr_o;
   logic                flush_o;
   logic                hold_o;
   logic                irq_ack_o;
   logic [CNT_W-1:0]    hold_cnt_o;

   modport master (
      output jump_en_i, jump_addr_i, hold_req_i, irq_req_i, irq_vec_i, cnt_clr_i,
      input  jump_en_o, jump_addr_o, flush_o, hold_o, irq_ack_o, hold_cnt_o
   );

   modport slave (
      input  jump_en_i, jump_addr_i, hold_req_i, irq_req_i, irq_vec_i, cnt_clr_i,
      output jump_en_o, jump_addr_o, flush_o, hold_o, irq_ack_o, hold_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates EXU redirects and interrupts into a registered jump pulse
// plus a flush window, merges hold requests into the fetch/decode stall, counts stall cycles.
module pipe_ctrl #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned NUM_HOLD     = 3,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_ctrl_if.slave  bus
);

   localparam int unsigned FCNT_W     = 4;
   localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_CYCLES - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [FCNT_W-1:0]   flush_cnt, flush_cnt_nxt;

   logic                jump_en_q, jump_en_nxt;
   logic [ADDR_W-1:0]   jump_addr_q, jump_addr_nxt;
   logic                flush_q, flush_nxt;
   logic                irq_ack_q, irq_ack_nxt;
   logic [CNT_W-1:0]    hold_cnt_q;

   logic [NUM_HOLD-1:0] hold_req;
   logic                hold_any_c;

   assign hold_req   = bus.hold_req_i;
   assign hold_any_c = |hold_req;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         flush_cnt   <= '0;
         jump_en_q   <= 1'b0;
         jump_addr_q <= '0;
         flush_q     <= 1'b0;
         irq_ack_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         flush_cnt   <= flush_cnt_nxt;
         jump_en_q   <= jump_en_nxt;
         jump_addr_q <= jump_addr_nxt;
         flush_q     <= flush_nxt;
         irq_ack_q   <= irq_ack_nxt;
      end
   end

   // Redirect arbitration (EXU > hold > IRQ) and flush window sequencing
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      jump_en_nxt   = 1'b0;
      jump_addr_nxt = jump_addr_q;
      flush_nxt     = 1'b0;
      irq_ack_nxt   = 1'b0;

      case (state)
         IDLE: begin
            if (bus.jump_en_i) begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = FLUSH_LAST;
               jump_en_nxt   = 1'b1;
               jump_addr_nxt = bus.jump_addr_i;
               flush_nxt     = 1'b1;
            end else if (bus.irq_req_i && !hold_any_c) begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = FLUSH_LAST;
               jump_en_nxt   = 1'b1;
               jump_addr_nxt = bus.irq_vec_i;
               flush_nxt     = 1'b1;
               irq_ack_nxt   = 1'b1;
            end
         end
         FLUSH: begin
            // Requests arriving here target already-flushed work and are dropped
            if (flush_cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               flush_cnt_nxt = flush_cnt - FCNT_W'(1);
               flush_nxt     = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Saturating count of cycles with any hold requester active
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
      end else if (bus.cnt_clr_i) begin
         hold_cnt_q <= '0;
      end else if (hold_any_c && (hold_cnt_q != '1)) begin
         hold_cnt_q <= hold_cnt_q + CNT_W'(1);
      end
   end

   assign bus.jump_en_o   = jump_en_q;
   assign bus.jump_addr_o = jump_addr_q;
   assign bus.flush_o     = flush_q;
   assign bus.irq_ack_o   = irq_ack_q;
   assign bus.hold_cnt_o  = hold_cnt_q;
   // Same-cycle stall path from the requesters is intentional
   assign bus.hold_o      = hold_any_c | flush_q;

endmodule
